mux16_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the 16:1 word mux (mux16). Up to 16 requesters

---
 rtl/mux16_pkg.sv | 10 +
 rtl/mux16_rr_arbiter_if.sv | 29 ++
 rtl/mux16_rr_pick.sv | 28 ++
 rtl/mux16_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux16_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux16_pkg.sv
// Shared types and widths for the mux16 round-robin arbiter slice.
package mux16_pkg;
  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_REQ-1:0] req_t;

  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Request/handshake bundle between requesters, downstream consumer and the arbiter.
interface mux16_rr_arbiter_if;
  import mux16_pkg::*;

  req_t req;
  logic out_ready;
  sel_t select;
  req_t grant;
  logic out_valid;
  logic busy;

  modport slave (
    input  req,
    input  out_ready,
    output select,
    output grant,
    output out_valid,
    output busy
  );

  modport master (
    output req,
    output out_ready,
    input  select,
    input  grant,
    input  out_valid,
    input  busy
  );
endinterface

// File: rtl/mux16_rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after start, wrapping mod 16.
module mux16_rr_pick
  import mux16_pkg::*;
(
  input  req_t req,
  input  sel_t start,
  output sel_t idx,
  output logic found
);

  logic [2*N_REQ-2:0] dbl;
  req_t               rot;
  sel_t               off;

  // Rotate by start through a doubled vector, then find the lowest set bit
  always_comb begin
    dbl = {req[N_REQ-2:0], req};
    rot = dbl[start +: N_REQ];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign idx   = start + off;
  assign found = |req;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter/sequencer for mux16: registered select/grant held until
// the downstream handshake, with bounded back-to-back bursts per grant.
module mux16_rr_arbiter
  import mux16_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  mux16_rr_arbiter_if.slave bus
);

  localparam sel_t BURST_LAST = SEL_W'(MAX_BURST - 1);

  arb_state_t state, state_nxt;
  sel_t       ptr, ptr_nxt;
  sel_t       burst_cnt, burst_nxt;
  sel_t       sel_r, sel_nxt;
  req_t       grant_r, grant_nxt;
  logic       valid_r, busy_r;

  req_t masked;
  req_t pick_req;
  sel_t pick_start;
  sel_t pick_idx;
  logic pick_found;
  logic move_on;

  // IDLE searches from ptr; GRANT searches the others starting just past the holder
  assign masked     = bus.req & ~(req_t'(1) << sel_r);
  assign pick_req   = (state == IDLE) ? bus.req : masked;
  assign pick_start = (state == IDLE) ? ptr : sel_r + SEL_W'(1);

  mux16_rr_pick u_pick (
    .req   (pick_req),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      burst_cnt <= '0;
      sel_r     <= '0;
      grant_r   <= '0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= burst_nxt;
      sel_r     <= sel_nxt;
      grant_r   <= grant_nxt;
      valid_r   <= (state_nxt == GRANT);
      busy_r    <= (state_nxt == GRANT);
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    burst_nxt = burst_cnt;
    sel_nxt   = sel_r;
    move_on   = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idx;
          burst_nxt = '0;
        end
      end
      GRANT: begin
        // A handshake always counts, even if the holder drops its request this cycle
        if (bus.out_ready) begin
          if (bus.req[sel_r] && (burst_cnt < BURST_LAST)) begin
            burst_nxt = burst_cnt + SEL_W'(1);
          end else begin
            move_on = 1'b1;
          end
        end else if (!bus.req[sel_r]) begin
          move_on = 1'b1;
        end

        if (move_on) begin
          ptr_nxt = sel_r + SEL_W'(1);
          if (pick_found) begin
            sel_nxt   = pick_idx;
            burst_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    grant_nxt = (state_nxt == GRANT) ? (req_t'(1) << sel_nxt) : '0;
  end

  assign bus.select    = sel_r;
  assign bus.grant     = grant_r;
  assign bus.out_valid = valid_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed scenarios plus a cycle-level scoreboard
// model run against a MAX_BURST=4 and a MAX_BURST=1 instance in parallel.
`timescale 1ns/1ps
module tb_mux16_rr_arbiter;
  import mux16_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_t req;
  logic rdy;

  mux16_rr_arbiter_if b4 ();
  mux16_rr_arbiter_if b1 ();

  assign b4.req       = req;
  assign b4.out_ready = rdy;
  assign b1.req       = req;
  assign b1.out_ready = rdy;

  mux16_rr_arbiter #(.MAX_BURST(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  mux16_rr_arbiter #(.MAX_BURST(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the arbiter, one call per clock edge
  typedef struct packed {
    logic g;
    sel_t ptr;
    sel_t bc;
    sel_t sel;
  } mst_t;

  function automatic sel_t pick_m(input req_t r, input sel_t s);
    sel_t k = s;
    for (int n = 0; n < 16; n++) begin
      if (r[k]) return k;
      k = k + 4'd1;
    end
    return s;
  endfunction

  function automatic mst_t step_m(input mst_t s, input req_t r, input logic rd, input int mb);
    mst_t o  = s;
    logic mv = 1'b0;
    req_t m;
    if (!s.g) begin
      if (r != '0) begin
        o.g   = 1'b1;
        o.sel = pick_m(r, s.ptr);
        o.bc  = '0;
      end
    end else begin
      if (rd) begin
        if (r[s.sel] && (int'(s.bc) < mb - 1)) o.bc = s.bc + 4'd1;
        else mv = 1'b1;
      end else if (!r[s.sel]) begin
        mv = 1'b1;
      end
      if (mv) begin
        m        = r;
        m[s.sel] = 1'b0;
        o.ptr    = s.sel + 4'd1;
        if (m != '0) begin
          o.sel = pick_m(m, o.ptr);
          o.bc  = '0;
        end else begin
          o.g = 1'b0;
        end
      end
    end
    return o;
  endfunction

  function automatic logic [21:0] obs_m(input mst_t s);
    req_t gr = '0;
    if (s.g) gr[s.sel] = 1'b1;
    return {s.g, s.g, gr, s.sel};
  endfunction

  function automatic logic inv_ok(input logic v, input logic b, input req_t g, input sel_t s);
    return (b == v) && $onehot0(g) && (v ? (g == (req_t'(1) << s)) : (g == '0));
  endfunction

  mst_t        m4, m1;
  logic [21:0] q4[$];
  logic [21:0] q1[$];
  logic        rand_on = 1'b0;
  int          wait4[16];
  int          wait1[16];
  int          maxw4 = 0;
  int          maxw1 = 0;

  // Model advance and fairness tracking; DUT outputs read here are pre-edge values
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4 = '0;
      m1 = '0;
      q4.delete();
      q1.delete();
      for (int i = 0; i < 16; i++) begin
        wait4[i] = 0;
        wait1[i] = 0;
      end
    end else begin
      if (rand_on) begin
        for (int i = 0; i < 16; i++) begin
          if (!req[i] || b4.grant[i]) wait4[i] = 0;
          else if (b4.out_valid && rdy) wait4[i]++;
          if (!req[i] || b1.grant[i]) wait1[i] = 0;
          else if (b1.out_valid && rdy) wait1[i]++;
          if (wait4[i] > maxw4) maxw4 = wait4[i];
          if (wait1[i] > maxw1) maxw1 = wait1[i];
        end
      end
      m4 = step_m(m4, req, rdy, 4);
      m1 = step_m(m1, req, rdy, 1);
      q4.push_back(obs_m(m4));
      q1.push_back(obs_m(m1));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (q4.size() > 0)
        chk("sb4", 32'({b4.out_valid, b4.busy, b4.grant, b4.select}), 32'(q4.pop_front()));
      if (q1.size() > 0)
        chk("sb1", 32'({b1.out_valid, b1.busy, b1.grant, b1.select}), 32'(q1.pop_front()));
      chk("inv4", 32'(inv_ok(b4.out_valid, b4.busy, b4.grant, b4.select)), 32'd1);
      chk("inv1", 32'(inv_ok(b1.out_valid, b1.busy, b1.grant, b1.select)), 32'd1);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Asserts reset away from any clock edge and checks outputs clear before a clock
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async4", 32'({b4.out_valid, b4.busy, b4.grant, b4.select}), 32'd0);
    chk("rst_async1", 32'({b1.out_valid, b1.busy, b1.grant, b1.select}), 32'd0);
    req = '0;
    rdy = 1'b0;
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [5:0] ev;
    req_t       flip;

    req = '0;
    rdy = 1'b0;
    #12 rst = 1'b0;
    #1 chk("reset_valid", 32'(b4.out_valid), 32'd0);

    // Reset mid-grant with every requester active
    req = 16'hFFFF;
    repeat (3) cyc();
    chk("t1_busy", 32'(b4.busy), 32'd1);
    do_reset();
    repeat (3) begin
      cyc();
      chk("t1_idle", 32'({b4.out_valid, b4.grant}), 32'd0);
    end

    // Two requesters alternate with MAX_BURST=1
    do_reset();
    req = 16'h0101;
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t2_sel", 32'(b1.select), (k % 2 == 1) ? 32'd8 : 32'd0);
      chk("t2_valid", 32'(b1.out_valid), 32'd1);
    end

    // Single requester bursts 4 words, one idle cycle, then regrant
    do_reset();
    req = 16'h0004;
    rdy = 1'b1;
    ev  = 6'b101111;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t3_valid", 32'(b4.out_valid), 32'(ev[k]));
      if (ev[k]) chk("t3_sel", 32'(b4.select), 32'd2);
    end

    // Wrap from 15 to 0
    do_reset();
    req = 16'h8000;
    cyc();
    chk("t4_sel15", 32'(b1.select), 32'd15);
    req = 16'h8001;
    rdy = 1'b1;
    cyc();
    chk("t4_wrap", 32'(b1.select), 32'd0);
    cyc();
    chk("t4_ptr", 32'(u_dut1.ptr), 32'd1);
    chk("t4_back", 32'(b1.select), 32'd15);

    // Stall, withdrawal, then handshake on regrant
    do_reset();
    req = 16'h0008;
    cyc();
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t5_stall", 32'({b4.out_valid, b4.select}), 32'h13);
    end
    req = '0;
    cyc();
    chk("t5_drop", 32'(b4.out_valid), 32'd0);
    req = 16'h0008;
    rdy = 1'b1;
    cyc();
    chk("t5_regrant", 32'({b4.out_valid, b4.select, u_dut4.burst_cnt}), 32'h130);
    cyc();
    chk("t5_counted", 32'(u_dut4.burst_cnt), 32'd1);

    // Random traffic checked by the scoreboard and fairness bound
    do_reset();
    rand_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      flip = '0;
      for (int i = 0; i < 16; i++) flip[i] = ($urandom_range(0, 7) == 0);
      req = req ^ flip;
      rdy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rand_on = 1'b0;
    chk("starve4", 32'(maxw4 <= 60), 32'd1);
    chk("starve1", 32'(maxw1 <= 15), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
